// File: rtl/dma_pkg.sv
// dma_pkg: constants and types shared by the DMA read/write channels.
// Contents: AXI burst/cache encodings, AXI response codes, MM2S FSM state enum.
// No ports; imported with `import dma_pkg::*;`.
package dma_pkg;

  localparam logic [1:0] BURST_INCR                = 2'b01;
  localparam logic [3:0] CACHE_NORMAL_NONCACH_BUFF = 4'b0011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } mm2s_state_t;

endpackage

// File: rtl/dma_skid_buffer.sv
// dma_skid_buffer: 2-entry skid buffer with fully registered outputs and registered in_rdy.
// Latency: a word accepted in cycle K is presented on out_* in cycle K+1; full throughput.
// Backpressure: in_rdy drops only when the skid slot is occupied, so out_rdy never reaches in_rdy combinationally.
// Ports: clk/rst (async active-high), in_vld/in_rdy/in_dat upstream, out_vld/out_rdy/out_dat downstream, empty = no word held.
module dma_skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             empty
);

  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;
  logic             push;
  logic             pop;

  assign in_rdy = ~skid_vld;
  assign push   = in_vld & in_rdy;
  assign pop    = out_vld & out_rdy;
  assign empty  = ~out_vld & ~skid_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (!out_vld || pop) begin
      // Output slot frees up: refill from the skid slot first to keep order.
      if (skid_vld) begin
        out_dat  <= skid_dat;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= push;
        if (push) out_dat <= in_dat;
      end
    end else if (push) begin
      // Output stalled: park the word accepted under the still-high in_rdy.
      skid_dat <= in_dat;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/mm2s_read_channel.sv
// mm2s_read_channel: issues one AXI4 INCR read burst per start edge and forwards beats to AXI4-Stream, tlast from own beat count.
// Latency: arvalid/busy one cycle after an accepted start; R->stream 0 cycles, or 1 cycle with MM2S_SKID_BUF_EN defined.
// Backpressure: tready throttles rready (combinational pass-through, or via skid-buffer fullness with MM2S_SKID_BUF_EN).
// Ports: m_mm2s_axi_ar*/r* = AXI4 read master, m_mm2s_axis_* = stream master, read_* = start/addr/len/size/busy/error control.
// Build option: MM2S_SKID_BUF_EN inserts dma_skid_buffer in the R->stream path.
module mm2s_read_channel
  import dma_pkg::*;
#(
  parameter int DMA_DATA_WIDTH_DST = 64,
  parameter int DMA_AXI_ADDR_WIDTH = 32
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  output logic [DMA_AXI_ADDR_WIDTH-1:0] m_mm2s_axi_araddr,
  output logic [1:0]                    m_mm2s_axi_arburst,
  output logic [3:0]                    m_mm2s_axi_arcache,
  output logic [7:0]                    m_mm2s_axi_arlen,
  output logic [2:0]                    m_mm2s_axi_arprot,
  output logic [2:0]                    m_mm2s_axi_arsize,
  output logic                          m_mm2s_axi_arvalid,
  input  logic                          m_mm2s_axi_arready,
  input  logic [DMA_DATA_WIDTH_DST-1:0] m_mm2s_axi_rdata,
  input  logic [1:0]                    m_mm2s_axi_rresp,
  input  logic                          m_mm2s_axi_rlast,
  input  logic                          m_mm2s_axi_rvalid,
  output logic                          m_mm2s_axi_rready,
  output logic [DMA_DATA_WIDTH_DST-1:0] m_mm2s_axis_tdata,
  output logic                          m_mm2s_axis_tlast,
  output logic                          m_mm2s_axis_tvalid,
  input  logic                          m_mm2s_axis_tready,
  input  logic                          read_start_i,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0] read_addr_i,
  input  logic [7:0]                    read_len_i,
  input  logic [2:0]                    read_size_i,
  output logic                          read_busy_o,
  output logic                          read_error_o
);

  mm2s_state_t                   state;
  mm2s_state_t                   state_nxt;
  logic                          start_q;
  logic                          start;
  logic                          accept;
  logic                          in_data;
  logic                          r_hs;
  logic                          last_beat;
  logic                          beat_err;
  logic                          path_empty;
  logic [DMA_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                    len_q;
  logic [2:0]                    size_q;
  logic [7:0]                    beat_cnt;
  logic                          err_q;

  assign start     = read_start_i & ~start_q;
  assign accept    = start & (state == IDLE);
  assign in_data   = (state == DATA);
  assign r_hs      = m_mm2s_axi_rvalid & m_mm2s_axi_rready;
  assign last_beat = (beat_cnt == len_q);
  // rlast is only cross-checked against our own count, never trusted for framing.
  assign beat_err  = (m_mm2s_axi_rresp != RESP_OKAY) | (m_mm2s_axi_rlast != last_beat);

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= read_start_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADDR;
      ADDR:    if (m_mm2s_axi_arready) state_nxt = DATA;
      DATA:    if (r_hs && last_beat) state_nxt = DRAIN;
      DRAIN:   if (path_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // accept and r_hs are exclusive: rready is low outside DATA.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= read_addr_i;
      len_q    <= read_len_i;
      size_q   <= read_size_i;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (r_hs) begin
      beat_cnt <= beat_cnt + 8'd1;
      if (beat_err) err_q <= 1'b1;
    end
  end

  assign m_mm2s_axi_araddr  = addr_q;
  assign m_mm2s_axi_arburst = BURST_INCR;
  assign m_mm2s_axi_arcache = CACHE_NORMAL_NONCACH_BUFF;
  assign m_mm2s_axi_arlen   = len_q;
  assign m_mm2s_axi_arprot  = 3'b000;
  assign m_mm2s_axi_arsize  = size_q;
  assign m_mm2s_axi_arvalid = (state == ADDR);
  assign read_busy_o        = (state != IDLE);
  assign read_error_o       = err_q;

`ifdef MM2S_SKID_BUF_EN
  localparam int PW = DMA_DATA_WIDTH_DST + 1;

  logic          buf_in_rdy;
  logic [PW-1:0] buf_out_dat;

  dma_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (m_axi_aclk),
    .rst     (m_axi_areset),
    .in_vld  (m_mm2s_axi_rvalid & in_data),
    .in_rdy  (buf_in_rdy),
    .in_dat  ({m_mm2s_axi_rdata, last_beat}),
    .out_vld (m_mm2s_axis_tvalid),
    .out_rdy (m_mm2s_axis_tready),
    .out_dat (buf_out_dat),
    .empty   (path_empty)
  );

  assign m_mm2s_axi_rready = in_data & buf_in_rdy;
  assign m_mm2s_axis_tdata = buf_out_dat[PW-1:1];
  assign m_mm2s_axis_tlast = buf_out_dat[0];
`else
  assign path_empty         = 1'b1;
  assign m_mm2s_axi_rready  = in_data & m_mm2s_axis_tready;
  assign m_mm2s_axis_tvalid = in_data & m_mm2s_axi_rvalid;
  assign m_mm2s_axis_tdata  = m_mm2s_axi_rdata;
  assign m_mm2s_axis_tlast  = last_beat;
`endif

endmodule
